// File: rtl/id_inst_latch.sv
// id_inst_latch
//   Fetch-to-decode register stage in front of the immediate generator.
//   IMEM/BIOS reads are synchronous, so the word for an address issued in
//   cycle N shows up on imem_dout in cycle N+1. This block remembers which
//   read is in flight, captures the word into a holding register when
//   decode stalls, and drops it on a flush. It presents the decode
//   instruction, its PC and the ImmSel code.
//
// Ports
//   clk, rst        core clock, synchronous active-high reset
//   fetch_valid/pc  read issued to IMEM this cycle, and its address
//   imem_dout       data for the read issued in the previous cycle
//   stall, flush    decode hold request, and squash/redirect
//   id_valid/inst/pc  decode instruction, its PC, and a valid flag
//   id_imm_sel      ImmSel: I=000 S=001 B=010 J=011 U=100 C=101
//   id_illegal      valid instruction with an unsupported opcode
//   hold_cycles     free-running count of cycles spent in HOLD
module id_inst_latch #(
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_pc,
    input  logic [31:0]          imem_dout,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 id_valid,
    output logic [31:0]          id_inst,
    output logic [31:0]          id_pc,
    output logic [2:0]           id_imm_sel,
    output logic                 id_illegal,
    output logic [CNT_WIDTH-1:0] hold_cycles
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_S = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_J = 3'b011;
    localparam logic [2:0] SEL_U = 3'b100;
    localparam logic [2:0] SEL_C = 3'b101;

    logic [0:0]           state_q,     state_d;
    logic                 pend_v_q,    pend_v_d;
    logic [31:0]          pend_pc_q,   pend_pc_d;
    logic [31:0]          hold_inst_q, hold_inst_d;
    logic [CNT_WIDTH-1:0] hold_cnt_q,  hold_cnt_d;

    // Next-state logic. The priority order is flush, then stall, then
    // normal advance. A flush loads the redirect target in the same cycle.
    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_pc_d   = pend_pc_q;
        hold_inst_d = hold_inst_q;
        hold_cnt_d  = hold_cnt_q;

        // Counts every cycle that starts in HOLD, including a flush cycle.
        if (state_q == ST_HOLD) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        if (flush) begin
            state_d   = ST_RUN;
            pend_v_d  = fetch_valid;
            pend_pc_d = fetch_pc;
        end else if (stall) begin
            // Only the first stalled cycle sees the real read data. Later
            // cycles keep the captured word and ignore imem_dout.
            if (state_q == ST_RUN) begin
                hold_inst_d = imem_dout;
                state_d     = ST_HOLD;
            end
        end else begin
            state_d   = ST_RUN;
            pend_v_d  = fetch_valid;
            pend_pc_d = fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_v_q    <= 1'b0;
            pend_pc_q   <= 32'h0;
            hold_inst_q <= NOP_INST;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_pc_q   <= pend_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    // Decode-side view
    always_comb begin
        if (state_q == ST_HOLD) begin
            id_inst = hold_inst_q;
        end else begin
            id_inst = pend_v_q ? imem_dout : NOP_INST;
        end
    end

    assign id_valid    = pend_v_q;
    assign id_pc       = pend_pc_q;
    assign hold_cycles = hold_cnt_q;

    // ImmSel decode. OP has no immediate, so it reports a fixed I.
    logic opc_bad;

    always_comb begin
        id_imm_sel = SEL_I;
        opc_bad    = 1'b0;
        case (id_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: id_imm_sel = SEL_I;
            7'b0100011:                         id_imm_sel = SEL_S;
            7'b1100011:                         id_imm_sel = SEL_B;
            7'b1101111:                         id_imm_sel = SEL_J;
            7'b0110111, 7'b0010111:             id_imm_sel = SEL_U;
            7'b0110011:                         id_imm_sel = SEL_I;
            // Within SYSTEM, funct3[2] marks the csrr*i forms (zimm).
            7'b1110011: id_imm_sel = id_inst[14] ? SEL_C : SEL_I;
            default: begin
                id_imm_sel = SEL_I;
                opc_bad    = 1'b1;
            end
        endcase
    end

    assign id_illegal = id_valid & opc_bad;

endmodule

// File: tb/tb_id_inst_latch.sv
module tb_id_inst_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] imem_dout;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [2:0]  id_imm_sel;
    logic        id_illegal;
    logic [31:0] hold_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    id_inst_latch dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_valid (fetch_valid),
        .fetch_pc    (fetch_pc),
        .imem_dout   (imem_dout),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_imm_sel  (id_imm_sel),
        .id_illegal  (id_illegal),
        .hold_cycles (hold_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    // Step one cycle. New inputs are applied 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic        ill;
    } vec_t;

    vec_t sweep[10];

    initial begin
        sweep[0] = '{32'h0000006F, 3'b011, 1'b0};  // JAL
        sweep[1] = '{32'h000012B7, 3'b100, 1'b0};  // LUI
        sweep[2] = '{32'h00125073, 3'b101, 1'b0};  // csrrwi
        sweep[3] = '{32'h00102073, 3'b000, 1'b0};  // csrrs
        sweep[4] = '{32'h00000023, 3'b001, 1'b0};  // STORE
        sweep[5] = '{32'h0000007F, 3'b000, 1'b1};  // unsupported
        sweep[6] = '{32'h00000063, 3'b010, 1'b0};  // BRANCH
        sweep[7] = '{32'h00000033, 3'b000, 1'b0};  // OP
        sweep[8] = '{32'h00000017, 3'b100, 1'b0};  // AUIPC
        sweep[9] = '{32'h00000003, 3'b000, 1'b0};  // LOAD

        rst = 1'b1; fetch_valid = 1'b0; fetch_pc = 32'h0;
        imem_dout = 32'hDEAD_BEEF; stall = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_inst", id_inst, 32'h00000013);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_sel", {29'b0, id_imm_sel}, 32'd0);
        chk("rst_ill", {31'b0, id_illegal}, 32'd0);
        chk("rst_cnt", hold_cycles, 32'd0);

        // T1: fetch 0x1000, data arrives next cycle
        fetch_valid = 1'b1; fetch_pc = 32'h1000;
        tick();
        fetch_pc = 32'h1004; imem_dout = 32'h00500093;
        #1;
        chk("t1_valid", {31'b0, id_valid}, 32'd1);
        chk("t1_pc", id_pc, 32'h1000);
        chk("t1_inst", id_inst, 32'h00500093);
        chk("t1_sel", {29'b0, id_imm_sel}, 32'd0);
        chk("t1_ill", {31'b0, id_illegal}, 32'd0);

        // T2: branch at 0x1004, stall three cycles, junk data after the first
        tick();
        fetch_valid = 1'b0; imem_dout = 32'hFEE78AE3; stall = 1'b1;
        #1;
        chk("t2_inst_c1", id_inst, 32'hFEE78AE3);
        chk("t2_sel_c1", {29'b0, id_imm_sel}, 32'd2);
        tick();
        imem_dout = 32'h12345678;
        #1;
        chk("t2_inst_c2", id_inst, 32'hFEE78AE3);
        chk("t2_sel_c2", {29'b0, id_imm_sel}, 32'd2);
        tick();
        imem_dout = 32'h0000007F;
        #1;
        chk("t2_inst_c3", id_inst, 32'hFEE78AE3);
        chk("t2_sel_c3", {29'b0, id_imm_sel}, 32'd2);
        tick();
        stall = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h1008; imem_dout = 32'hAAAA5555;
        #1;
        chk("t2_inst_c4", id_inst, 32'hFEE78AE3);
        chk("t2_sel_c4", {29'b0, id_imm_sel}, 32'd2);
        chk("t2_pc_c4", id_pc, 32'h1004);
        tick();
        fetch_valid = 1'b0; imem_dout = 32'h11111093;
        #1;
        chk("t2_cnt", hold_cycles, 32'd3);
        chk("t2_next_pc", id_pc, 32'h1008);
        chk("t2_next_inst", id_inst, 32'h11111093);

        // T3: enter HOLD, then flush to 0x2000
        stall = 1'b1;
        tick();
        imem_dout = 32'h55555555;
        flush = 1'b1; stall = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h2000;
        #1;
        chk("t3_held", id_inst, 32'h11111093);
        tick();
        flush = 1'b0; fetch_valid = 1'b0; imem_dout = 32'h00C00513;
        #1;
        chk("t3_pc", id_pc, 32'h2000);
        chk("t3_inst", id_inst, 32'h00C00513);
        chk("t3_valid", {31'b0, id_valid}, 32'd1);
        chk("t3_cnt", hold_cycles, 32'd4);

        // T6: flush and stall in the same cycle, flush wins
        flush = 1'b1; stall = 1'b1; fetch_valid = 1'b1; fetch_pc = 32'h3000;
        tick();
        flush = 1'b0; stall = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h3004;
        imem_dout = 32'h00000023;
        #1;
        chk("t6_pc", id_pc, 32'h3000);
        chk("t6_inst", id_inst, 32'h00000023);
        imem_dout = 32'h0000006F;
        #1;
        chk("t6_run_follow", id_inst, 32'h0000006F);
        tick();
        chk("t6_cnt", hold_cycles, 32'd4);

        // T4: opcode sweep while a valid instruction sits in RUN
        for (int i = 0; i < 10; i++) begin
            imem_dout = sweep[i].inst;
            #1;
            chk($sformatf("t4_sel_%0d", i), {29'b0, id_imm_sel}, {29'b0, sweep[i].sel});
            chk($sformatf("t4_ill_%0d", i), {31'b0, id_illegal}, {31'b0, sweep[i].ill});
        end
        imem_dout = 32'h00000001;
        #1;
        chk("t4_ill_lowbits", {31'b0, id_illegal}, 32'd1);

        // Bad opcode held with no valid instruction must not flag illegal
        fetch_valid = 1'b0;
        tick();
        stall = 1'b1; imem_dout = 32'h0000007F;
        #1;
        chk("inv_run_inst", id_inst, 32'h00000013);
        tick();
        imem_dout = 32'h0;
        #1;
        chk("inv_hold_inst", id_inst, 32'h0000007F);
        chk("inv_hold_valid", {31'b0, id_valid}, 32'd0);
        chk("inv_hold_ill", {31'b0, id_illegal}, 32'd0);
        tick();
        chk("inv_cnt", hold_cycles, 32'd5);

        // T5: reset while in HOLD
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0; imem_dout = 32'hFEE78AE3;
        #1;
        chk("t5_valid", {31'b0, id_valid}, 32'd0);
        chk("t5_inst", id_inst, 32'h00000013);
        chk("t5_pc", id_pc, 32'h0);
        chk("t5_cnt", hold_cycles, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
